// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//   Bank of CHANNELS independent programmable dividers, all clocked by clk.
//   Each channel counts enabled cycles up to an effective divisor
//   D = max(div, 1). On the last count the channel expires, which raises a
//   one-cycle tick and updates out according to the channel mode:
//     00 toggle   : out inverts on every expiry (period 2*D)
//     01 pulse    : out mirrors tick
//     10 one-shot : out latches high on the first expiry and the channel
//                   then stays quiet until it is reconfigured
//     11 off      : counter, out and tick held at zero
//
// Ports
//   clk      in   clock, every state change on its rising edge
//   rst_n    in   synchronous active-low reset (defaults: div=DIVISOR, toggle)
//   en       in   per-channel count enable
//   sync     in   clears counters/outputs of every channel (phase alignment)
//   cfg_we   in   configuration write strobe
//   cfg_ch   in   channel addressed by cfg_we (out-of-range writes ignored)
//   cfg_div  in   divisor to load
//   cfg_mode in   mode to load
//   out      out  registered divided output per channel
//   tick     out  registered one-cycle expiry strobe per channel
// ---------------------------------------------------------------------------
module clk_div_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int DIVISOR  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic [1:0]          cfg_mode,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick
);

    typedef enum logic [1:0] {
        MODE_TOGGLE  = 2'b00,
        MODE_PULSE   = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_OFF     = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIVISOR);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [4:0]       CH_LIMIT = 5'(CHANNELS);

    // A stored divisor of zero behaves exactly like a divisor of one.
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
        return (d == ZERO) ? ONE : d;
    endfunction

    logic [WIDTH-1:0]    cnt_r  [CHANNELS];
    logic [WIDTH-1:0]    div_r  [CHANNELS];
    mode_e               mode_r [CHANNELS];
    logic [CHANNELS-1:0] out_r;
    logic [CHANNELS-1:0] tick_r;

    logic [WIDTH-1:0]    cnt_s  [CHANNELS];
    logic [WIDTH-1:0]    div_s  [CHANNELS];
    mode_e               mode_s [CHANNELS];
    logic [CHANNELS-1:0] out_s;
    logic [CHANNELS-1:0] tick_s;

    logic                cfg_hit_s;

    // A write to a channel index beyond the bank is dropped entirely.
    assign cfg_hit_s = cfg_we & (({1'b0, cfg_ch} < CH_LIMIT) ? 1'b1 : 1'b0);

    // Next-state computation for every channel: count, then sync, then cfg.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_s[i]  = cnt_r[i];
            div_s[i]  = div_r[i];
            mode_s[i] = mode_r[i];
            // Pulse mode tracks tick, so its out falls on any non-expiry edge.
            out_s[i]  = (mode_r[i] == MODE_PULSE) ? 1'b0 : out_r[i];
            tick_s[i] = 1'b0;

            if (mode_r[i] == MODE_OFF) begin
                cnt_s[i] = ZERO;
                out_s[i] = 1'b0;
            end else if (!en[i]) begin
                cnt_s[i] = cnt_r[i];
            end else if ((mode_r[i] == MODE_ONESHOT) && out_r[i]) begin
                // One-shot already fired: park the counter until reconfigured.
                cnt_s[i] = ZERO;
            end else if (cnt_r[i] == (eff_div(div_r[i]) - ONE)) begin
                cnt_s[i]  = ZERO;
                tick_s[i] = 1'b1;
                case (mode_r[i])
                    MODE_TOGGLE:  out_s[i] = ~out_r[i];
                    MODE_PULSE:   out_s[i] = 1'b1;
                    MODE_ONESHOT: out_s[i] = 1'b1;
                    default:      out_s[i] = 1'b0;
                endcase
            end else begin
                cnt_s[i] = cnt_r[i] + ONE;
            end

            if (sync) begin
                cnt_s[i]  = ZERO;
                out_s[i]  = 1'b0;
                tick_s[i] = 1'b0;
            end else begin
                // no alignment request: counting result stands
            end

            // Configuration wins over expiry on the addressed channel.
            if (cfg_hit_s && (4'(i) == cfg_ch)) begin
                div_s[i]  = cfg_div;
                mode_s[i] = mode_e'(cfg_mode);
                cnt_s[i]  = ZERO;
                out_s[i]  = 1'b0;
                tick_s[i] = 1'b0;
            end else begin
                // channel not addressed this cycle
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i]  <= ZERO;
                div_r[i]  <= DIV_RST;
                mode_r[i] <= MODE_TOGGLE;
            end
            out_r  <= {CHANNELS{1'b0}};
            tick_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i]  <= cnt_s[i];
                div_r[i]  <= div_s[i];
                mode_r[i] <= mode_s[i];
            end
            out_r  <= out_s;
            tick_r <= tick_s;
        end
    end

    assign out  = out_r;
    assign tick = tick_r;

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
//   Directed bench for clk_div_multi (CHANNELS=4, WIDTH=16, DIVISOR=5).
//   Stimulus walks a fixed edge-numbered scenario; for every edge k the
//   expected out/tick vector is pushed into a scoreboard queue, and a
//   monitor pops and compares one entry after each rising edge.
//   Edge numbering: k<=0 reset, k=1 first counting edge.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

    logic        clk;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_mode;
    logic [3:0]  out;
    logic [3:0]  tick;

    typedef struct {
        int         k;
        logic [3:0] eo;
        logic [3:0] et;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    clk_div_multi #(
        .CHANNELS (4),
        .WIDTH    (16),
        .DIVISOR  (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .out      (out),
        .tick     (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Toggle channel whose phase started at edge s with divisor d: {out,tick}.
    function automatic logic [1:0] tgl(input int k, input int s, input int d);
        logic t, o;
        t = (k > s) && (((k - s) % d) == 0);
        o = (((k - s) / d) % 2) == 1;
        return {o, t};
    endfunction

    // Pulse channel: out equals tick.
    function automatic logic [1:0] pls(input int k, input int s, input int d);
        logic t;
        t = (k > s) && (((k - s) % d) == 0);
        return {t, t};
    endfunction

    // One-shot channel armed at edge s: fires once on edge s+d, out stays high.
    function automatic logic [1:0] one(input int k, input int s, input int d);
        logic t, o;
        t = (k == s + d);
        o = (k >= s + d);
        return {o, t};
    endfunction

    // Hand-derived expectation for channel ch after edge k.
    function automatic logic [1:0] exp_ch(input int ch, input int k);
        if (k <= 0 || k == 87 || k == 88) return 2'b00;
        if (k >= 89) return tgl(k, 88, 5);
        case (ch)
            0: begin
                if (k <= 46)      return tgl(k, 0, 5);
                else if (k <= 53) return 2'b10;          // frozen by en[0]=0
                else if (k <= 66) return tgl(k - 7, 0, 5);
                else if (k <= 75) return tgl(k, 67, 5);  // rewritten on expiry edge
                else              return tgl(k, 76, 5);  // after sync
            end
            1: begin
                if (k <= 20)      return tgl(k, 0, 5);
                else if (k <= 75) return pls(k, 21, 3);
                else              return pls(k, 76, 3);
            end
            2: begin
                if (k <= 30)      return tgl(k, 0, 5);
                else if (k <= 40) return one(k, 31, 4);
                else if (k <= 75) return one(k, 41, 4);
                else              return 2'b00;          // switched off
            end
            3: begin
                if (k <= 60)      return tgl(k, 0, 5);
                else if (k <= 75) return tgl(k, 61, 1);  // div=0 acts as 1
                else              return tgl(k, 76, 1);
            end
            default: return 2'b00;
        endcase
    endfunction

    task automatic cfg(input logic [3:0] ch, input logic [15:0] d, input logic [1:0] m);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = d;
        cfg_mode = m;
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++;
                if (out !== mon_e.eo) begin
                    failures++;
                    $display("FAIL out k=%0d actual=%b expected=%b", mon_e.k, out, mon_e.eo);
                end
                checks++;
                if (tick !== mon_e.et) begin
                    failures++;
                    $display("FAIL tick k=%0d actual=%b expected=%b", mon_e.k, tick, mon_e.et);
                end
            end
        end
    end

    // Stimulus: drive edge k's inputs, queue its expectation, wait one cycle.
    initial begin
        exp_t       e;
        logic [1:0] r;
        rst_n    = 1'b0;
        en       = 4'hF;
        sync     = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = 4'd0;
        cfg_div  = 16'd0;
        cfg_mode = 2'b00;
        for (int k = -1; k <= 100; k++) begin
            rst_n  = (k <= 0 || k == 87 || k == 88) ? 1'b0 : 1'b1;
            en     = (k >= 47 && k <= 53) ? 4'hE : 4'hF;
            sync   = (k == 76) ? 1'b1 : 1'b0;
            cfg_we = 1'b0;
            case (k)
                21:      cfg(4'd1, 16'd3, 2'b01);
                31, 41:  cfg(4'd2, 16'd4, 2'b10);
                61:      cfg(4'd3, 16'd0, 2'b00);
                67:      cfg(4'd0, 16'd5, 2'b00);
                68:      cfg(4'd4, 16'd2, 2'b11);  // out of range, ignored
                76:      cfg(4'd2, 16'd4, 2'b11);  // together with sync
                87:      cfg(4'd1, 16'd2, 2'b11);  // overridden by reset
                default: cfg_we = 1'b0;
            endcase
            e.k = k;
            for (int ch = 0; ch < 4; ch++) begin
                r        = exp_ch(ch, k);
                e.eo[ch] = r[1];
                e.et[ch] = r[0];
            end
            sb.push_back(e);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent divider channels, 1..16.
REQ-002 SHALL have parameter WIDTH, default 16: width of each channel counter and divisor, 2..32.
REQ-003 SHALL have parameter DIVISOR, default 5: reset divisor loaded into every channel.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port en  input  CHANNELS: per-channel count enable.
REQ-007 SHALL have port sync  input  1: clears all channel counters and outputs for phase alignment.
REQ-008 SHALL have port cfg_we  input  1: configuration write strobe.
REQ-009 SHALL have port cfg_ch  input  4: target channel index for cfg_we.
REQ-010 SHALL have port cfg_div  input  WIDTH: new divisor for the target channel.
REQ-011 SHALL have port cfg_mode  input  2: new mode for the target channel: 00 toggle, 01 pulse, 10 one-shot, 11 off.
REQ-012 SHALL have port out  output  CHANNELS: registered per-channel divided output.
REQ-013 SHALL have port tick  output  CHANNELS: registered one-cycle expiry strobe per channel.

Function
REQ-014 SHALL keep per channel: counter cnt (WIDTH), divisor div (WIDTH), mode (2), out bit, tick bit.
REQ-015 SHALL treat a stored div of 0 as 1; effective divisor D = max(div,1).
REQ-016 SHALL, for an active channel (mode != 11) with en high, increment cnt on each edge while cnt < D-1.
REQ-017 SHALL, on the edge where cnt == D-1 with en high, set cnt to 0 and tick to 1 (expiry).
REQ-018 SHALL drive tick to 0 on every edge that is not an expiry edge; tick never exceeds one cycle.
REQ-019 Mode 00: out SHALL invert on each expiry; with D=5, out period = 10 clk cycles, 50% duty.
REQ-020 Mode 01: out SHALL equal tick (high one cycle per D cycles).
REQ-021 Mode 10: on first expiry out SHALL go 1 and stay 1; cnt SHALL freeze at 0; no further ticks until reconfigured.
REQ-022 Mode 11: cnt, out, tick SHALL be held at 0 regardless of en.
REQ-023 With en low, a channel SHALL hold cnt and out, and tick SHALL be 0.
REQ-024 cfg_we with cfg_ch < CHANNELS SHALL load div and mode, clear cnt, out, tick of that channel on the same edge.
REQ-025 cfg_we with cfg_ch >= CHANNELS SHALL be ignored; no channel state changes.
REQ-026 cfg_we SHALL take priority over expiry on the target channel: no tick, out cleared.
REQ-027 sync SHALL clear cnt, out, tick of all channels on the same edge; div and mode retained.
REQ-028 sync together with cfg_we SHALL apply both: target channel reloaded, all channels cleared.
REQ-029 Channels SHALL be fully independent except for sync and shared cfg bus.
REQ-030 Divisor change on one channel SHALL not disturb phase of any other channel.

Reset
REQ-031 While rst_n is low at a rising edge, every channel SHALL set cnt=0, div=DIVISOR, mode=00, out=0, tick=0.
REQ-032 Reset SHALL override sync, cfg_we and en; reset mid-count SHALL discard count progress.
REQ-033 After rst_n rises with en high, first tick and first out toggle SHALL occur on the DIVISOR-th rising edge.

Verification
REQ-034 Reset, en=all 1, defaults -> every out toggles every 5 cycles (period 10), tick high 1 cycle every 5 cycles, all channels in phase.
REQ-035 cfg_we ch1 div=3 mode=01 -> out[1]==tick[1], high 1 of every 3 cycles; ch0 phase unchanged.
REQ-036 cfg_we ch2 div=4 mode=10 -> out[2] rises on 4th edge after write and stays 1, tick[2] once only; rewrite rearms.
REQ-037 en[0] low for 7 cycles mid-count -> cnt[0] and out[0] frozen, tick[0]=0; resumes from held count; div=0 write behaves as div=1 (toggle every cycle).
REQ-038 cfg_we on ch0 on its expiry edge -> no tick[0], out[0]=0; cfg_ch=CHANNELS -> no state change anywhere.
REQ-039 sync asserted with channels at differing phases -> all out=0, cnt=0 next cycle, then ticks realign; rst_n low mid-count -> all outputs 0, defaults restored.
